// File: rtl/audio_nios_clkgen_div.sv
// Multi-channel programmable clock divider with per-period enable strobes.
// Divisor changes take effect only at a period boundary (or on cfg_sync); locked reports settled outputs.
module audio_nios_clkgen_div #(
    parameter int                    N_CH        = 3,
    parameter int                    DIV_W       = 8,
    parameter logic [N_CH*DIV_W-1:0] DIV_INIT    = {8'd10, 8'd4, 8'd2},
    parameter int                    LOCK_CYCLES = 16,
    parameter int                    CH_W        = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_sync,
    output logic [N_CH-1:0]  outclk,
    output logic [N_CH-1:0]  outen,
    output logic             locked
);

    localparam int             LCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

    // A divisor of 1 cannot produce a 50% clock, so it is promoted to 2.
    function automatic logic [DIV_W-1:0] f_coerce(input logic [DIV_W-1:0] d);
        return (d == DIV_W'(1)) ? DIV_W'(2) : d;
    endfunction

    logic [N_CH-1:0] w_apply;
    logic            w_any_apply;
    logic [LCW-1:0]  r_lock_cnt;
    logic [LCW-1:0]  w_lock_nx;
    logic            r_locked;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam logic [DIV_W-1:0] INIT_DIV = f_coerce(DIV_INIT[g*DIV_W +: DIV_W]);

        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_pdiv;
        logic             r_pend;
        logic             r_clk;
        logic             r_en;

        logic             w_hit;
        logic             w_pend_eff;
        logic             w_active;
        logic             w_wrap;
        logic [DIV_W-1:0] w_pdiv_eff;
        logic [DIV_W-1:0] w_div_nx;
        logic [DIV_W-1:0] w_cnt_nx;
        logic [DIV_W:0]   w_half;

        assign w_hit      = cfg_wr && (32'(cfg_ch) == g);
        assign w_pend_eff = r_pend || w_hit;
        assign w_pdiv_eff = w_hit ? cfg_div : r_pdiv;
        assign w_active   = (r_div != '0);
        // A disabled channel sits permanently at its boundary, so pending values apply immediately.
        assign w_wrap     = !w_active || (r_cnt == r_div - DIV_W'(1));
        assign w_apply[g] = w_pend_eff && (cfg_sync || w_wrap);
        assign w_div_nx   = w_apply[g] ? f_coerce(w_pdiv_eff) : r_div;
        assign w_half     = ({1'b0, w_div_nx} + (DIV_W+1)'(1)) >> 1;

        always_comb begin
            w_cnt_nx = r_cnt + DIV_W'(1);
            if (cfg_sync || w_wrap) begin
                w_cnt_nx = '0;
            end
        end

        always_ff @(posedge refclk) begin
            if (rst) begin
                r_div  <= INIT_DIV;
                r_cnt  <= INIT_DIV - DIV_W'(1);
                r_pdiv <= '0;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_en   <= 1'b0;
            end else begin
                r_div  <= w_div_nx;
                r_cnt  <= w_cnt_nx;
                r_pdiv <= w_pdiv_eff;
                r_pend <= w_pend_eff && !w_apply[g];
                r_clk  <= (w_div_nx != '0) && ({1'b0, w_cnt_nx} < w_half);
                r_en   <= (w_div_nx != '0) && (w_cnt_nx == '0);
            end
        end

        assign outclk[g] = r_clk;
        assign outen[g]  = r_en;
    end

    assign w_any_apply = (|w_apply) || cfg_sync;
    assign w_lock_nx   = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + LCW'(1);

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_any_apply) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_lock_cnt <= w_lock_nx;
            r_locked   <= (w_lock_nx == LOCK_MAX);
        end
    end

    assign locked = r_locked;

endmodule

// File: doc/audio_nios_clkgen_div.md
Name: audio_nios_clkgen_div

Overview:
Multi-channel, runtime-programmable clock-divider and strobe generator. Runs on the PLL output clock. Each channel produces a divided clock (outclk) and a one-cycle clock-enable strobe (outen) for peripherals such as the audio codec, I2C and timers. Divisors are changed from a Nios-side register write without glitches, and a `locked` indication reports when every channel has been stable for a programmable settling time.

Parameters:
N_CH, 3, number of output channels (1..16)
DIV_W, 8, divisor width in bits
DIV_INIT, {8'd10,8'd4,8'd2}, packed N_CH*DIV_W reset divisors; channel i uses bits [i*DIV_W +: DIV_W]
LOCK_CYCLES, 16, stable cycles required before `locked` asserts (>=1)
CH_W, 2, width of cfg_ch (>= clog2(N_CH), minimum 1)

Ports:
refclk  in  1  sole clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
cfg_wr  in  1  one-cycle divisor write strobe
cfg_ch  in  CH_W  target channel of the write
cfg_div  in  DIV_W  new divisor value
cfg_sync  in  1  one-cycle strobe that phase-aligns all channels
outclk  out  N_CH  divided clocks, one bit per channel
outen  out  N_CH  one-cycle enable strobe at the start of each period
locked  out  1  all channels stable for LOCK_CYCLES cycles

Behaviour:
- Reset and interface: one clock, refclk; rst is synchronous and active-high.
- State per channel:
  - cnt: period counter.
  - D: active divisor.
  - P / pend: pending divisor and its valid flag.
- Global state: lock_cnt.
- Values while rst=1:
  - D = DIV_INIT slice; cnt = D-1 (pre-wrap); pend = 0.
  - outclk = 0, outen = 0, locked = 0, lock_cnt = 0.
- Divisor coding:
  - D=0: channel disabled; outclk and outen held 0.
  - D=1: coerced to 2 when loaded.
  - D>=2: period is D cycles; outclk is high for ceil(D/2) cycles (H) and low for floor(D/2).
- Counting: cnt counts 0..D-1, then wraps to 0. outclk and outen are registered and reflect the cnt value loaded on the same edge:
  - outclk <= (cnt_next < H)
  - outen <= (cnt_next == 0) for an enabled channel.
- Start-up: the first edge with rst=0 wraps every enabled channel. outclk and outen go high on that edge (latency 1).
- Write:
  - cfg_wr with cfg_ch < N_CH stores pend = 1, P = cfg_div.
  - cfg_ch >= N_CH: write ignored.
  - A later write before the apply overwrites P (last write wins).
  - No backpressure; a write is accepted every cycle.
- Apply (glitch-free):
  - Enabled channel: on the wrap edge (cnt == D-1), if a pending value exists (including a cfg_wr in that same cycle), D <= P, cnt <= 0, and the outputs use the new D.
  - Disabled channel (D=0): applies on the edge after the write.
- Sync: cfg_sync=1 forces all channels to apply pend (if set) and load cnt <= 0 on the next edge. All enabled outen bits then pulse together. A cfg_wr in the same cycle as cfg_sync is included in the apply.
- Lock:
  - lock_cnt increments each cycle, saturating at LOCK_CYCLES. locked = (lock_cnt == LOCK_CYCLES), registered.
  - Any apply or sync clears lock_cnt to 0 and locked to 0 on that edge. This holds even if the new value equals the old D.
  - Rises on the LOCK_CYCLES-th edge after release or after the last apply.
- Reset mid-operation: pending writes are discarded and DIV_INIT is restored; the first rst=0 edge behaves as start-up.
- Size: counters are DIV_W bits and lock_cnt is clog2(LOCK_CYCLES+1) bits; no arithmetic overflow is possible.

Test Plan:
1. Defaults (N_CH=3), release rst → ch0 toggles 1,0 every cycle; ch1 is 1,1,0,0; ch2 is 5 high / 5 low; outen[2] pulses every 10 cycles; all outen pulse on the first edge; locked rises on edge 16.
2. Write ch1 div=5 at cnt=1 → the current period completes (2 more cycles), then period 5 (3 high / 2 low); locked falls on the apply edge and rises 16 edges later.
3. Write ch0 div=1 → period 2. Write ch0 div=0 → outclk[0]/outen[0] go 0 at the next wrap. Write 3 → applied the next edge; outclk = 1,1,0 repeating.
4. ch1=4 and ch2=10 out of phase; pulse cfg_sync → next edge, outen=3'b111, all cnt=0; locked drops.
5. Write ch2 div=6, then rst for 1 cycle before the wrap → after release ch2 period is 10 (not 6); locked=0 until edge 16.
6. cfg_wr with cfg_ch=3, div=7 → no output change and locked stays 1. Two writes to ch1 (6 then 8) before the wrap → period 8 applied.
